// File: rtl/bp_be_sys_stage_pipe_if.sv
// rtl/bp_be_sys_stage_pipe_if.sv - PTW miss request / fill handshake channel
interface bp_be_sys_stage_pipe_if #(
  parameter int vaddr_width_p = 39
);
  logic                     miss_v;
  logic                     miss_ready;
  logic                     miss_instr;
  logic                     miss_store;
  logic [vaddr_width_p-1:0] miss_vaddr;
  logic                     fill_v;

  modport master (
    output miss_v, miss_instr, miss_store, miss_vaddr,
    input  miss_ready, fill_v
  );

  modport slave (
    input  miss_v, miss_instr, miss_store, miss_vaddr,
    output miss_ready, fill_v
  );
endinterface

// File: rtl/bp_be_sys_stage_pipe.sv
// rtl/bp_be_sys_stage_pipe.sv - system-pipe staging of CSR/commit metadata plus single-outstanding PTW miss FSM
module bp_be_sys_stage_pipe #(
  parameter int vaddr_width_p = 39,
  parameter int dword_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int fu_op_width_p = 5,
  parameter int stages_p      = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     v_i,
  input  logic                     csr_v_i,
  input  logic                     dcache_w_v_i,
  input  logic                     imm_sel_i,
  input  logic [fu_op_width_p-1:0] fu_op_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [instr_width_p-1:0] instr_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] imm_i,
  input  logic                     commit_v_i,
  input  logic                     itlb_miss_i,
  input  logic                     dtlb_miss_i,
  output logic                     v_o,
  output logic                     csr_cmd_v_o,
  output logic [fu_op_width_p-1:0] csr_op_o,
  output logic [11:0]              csr_addr_o,
  output logic [dword_width_p-1:0] csr_data_o,
  output logic [vaddr_width_p-1:0] commit_pc_o,
  output logic [vaddr_width_p-1:0] commit_vaddr_o,
  output logic [instr_width_p-1:0] commit_instr_o,
  bp_be_sys_stage_pipe_if.master   ptw,
  output logic                     ptw_busy_o,
  output logic                     miss_overrun_o
);
  localparam int last_lp = stages_p - 1;

  typedef enum logic [1:0] {e_idle, e_req, e_wait} miss_state_e;

  logic [stages_p-1:0]      v_q, v_d, csr_v_q, csr_v_d;
  logic [stages_p-1:0]      store_q;
  logic [fu_op_width_p-1:0] op_q    [stages_p];
  logic [vaddr_width_p-1:0] pc_q    [stages_p];
  logic [vaddr_width_p-1:0] vaddr_q [stages_p];
  logic [instr_width_p-1:0] instr_q [stages_p];
  logic [dword_width_p-1:0] data_q  [stages_p];
  logic [vaddr_width_p-1:0] vaddr_li;
  logic [dword_width_p-1:0] data_li;

  // Adding only the low bits gives the same result as a full-width add truncated afterwards.
  assign vaddr_li = rs1_i[vaddr_width_p-1:0] + imm_i[vaddr_width_p-1:0];
  assign data_li  = imm_sel_i ? imm_i : rs1_i;

  always_comb begin
    v_d        = '0;
    csr_v_d    = '0;
    v_d[0]     = v_i;
    csr_v_d[0] = csr_v_i;
    for (int k = 1; k < stages_p; k++) begin
      v_d[k]     = v_q[k-1];
      csr_v_d[k] = csr_v_q[k-1];
    end
    if (flush_i) begin
      v_d     = '0;
      csr_v_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q     <= '0;
      csr_v_q <= '0;
    end else begin
      v_q     <= v_d;
      csr_v_q <= csr_v_d;
    end
  end

  always_ff @(posedge clk_i) begin
    store_q[0] <= dcache_w_v_i;
    op_q[0]    <= fu_op_i;
    pc_q[0]    <= pc_i;
    vaddr_q[0] <= vaddr_li;
    instr_q[0] <= instr_i;
    data_q[0]  <= data_li;
    for (int k = 1; k < stages_p; k++) begin
      store_q[k] <= store_q[k-1];
      op_q[k]    <= op_q[k-1];
      pc_q[k]    <= pc_q[k-1];
      vaddr_q[k] <= vaddr_q[k-1];
      instr_q[k] <= instr_q[k-1];
      data_q[k]  <= data_q[k-1];
    end
  end

  assign v_o            = v_q[last_lp];
  assign csr_cmd_v_o    = v_q[last_lp] & csr_v_q[last_lp] & commit_v_i;
  assign csr_op_o       = op_q[last_lp];
  assign csr_addr_o     = instr_q[last_lp][31:20];
  assign csr_data_o     = data_q[last_lp];
  assign commit_pc_o    = pc_q[last_lp];
  assign commit_vaddr_o = vaddr_q[last_lp];
  assign commit_instr_o = instr_q[last_lp];

  miss_state_e              state_q, state_d;
  logic                     miss_instr_q, miss_store_q;
  logic [vaddr_width_p-1:0] miss_vaddr_q;
  logic                     miss_li, latch_en;

  assign miss_li = commit_v_i & (itlb_miss_i | dtlb_miss_i);

  always_comb begin
    state_d        = state_q;
    latch_en       = 1'b0;
    miss_overrun_o = 1'b0;
    case (state_q)
      e_idle: begin
        if (miss_li) begin
          state_d  = e_req;
          latch_en = 1'b1;
        end
      end
      e_req: begin
        miss_overrun_o = miss_li;
        if (ptw.miss_ready) state_d = e_wait;
      end
      e_wait: begin
        miss_overrun_o = miss_li;
        if (ptw.fill_v) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  // The walk is committed once requested, so flush never touches this state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_idle;
      miss_instr_q <= 1'b0;
      miss_store_q <= 1'b0;
      miss_vaddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        miss_instr_q <= itlb_miss_i;
        miss_store_q <= ~itlb_miss_i & store_q[last_lp];
        miss_vaddr_q <= itlb_miss_i ? pc_q[last_lp] : vaddr_q[last_lp];
      end
    end
  end

  assign ptw_busy_o     = (state_q != e_idle);
  assign ptw.miss_v     = (state_q == e_req);
  assign ptw.miss_instr = ptw_busy_o & miss_instr_q;
  assign ptw.miss_store = ptw_busy_o & miss_store_q;
  assign ptw.miss_vaddr = ptw_busy_o ? miss_vaddr_q : '0;

endmodule

// File: tb/tb_bp_be_sys_stage_pipe.sv
// tb/tb_bp_be_sys_stage_pipe.sv - table-driven and scoreboarded bench for bp_be_sys_stage_pipe
module tb_bp_be_sys_stage_pipe;
  localparam int vaddr_w = 39;
  localparam int dword_w = 64;
  localparam int instr_w = 32;
  localparam int op_w    = 5;
  localparam int stages  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_i, flush_i, v_i, csr_v_i, dcache_w_v_i, imm_sel_i;
  logic [op_w-1:0]    fu_op_i;
  logic [vaddr_w-1:0] pc_i;
  logic [instr_w-1:0] instr_i;
  logic [dword_w-1:0] rs1_i, imm_i;
  logic               commit_v_i, itlb_miss_i, dtlb_miss_i;
  logic               v_o, csr_cmd_v_o;
  logic [op_w-1:0]    csr_op_o;
  logic [11:0]        csr_addr_o;
  logic [dword_w-1:0] csr_data_o;
  logic [vaddr_w-1:0] commit_pc_o, commit_vaddr_o;
  logic [instr_w-1:0] commit_instr_o;
  logic               ptw_busy_o, miss_overrun_o;

  bp_be_sys_stage_pipe_if #(.vaddr_width_p(vaddr_w)) ptw ();

  bp_be_sys_stage_pipe #(
    .vaddr_width_p(vaddr_w), .dword_width_p(dword_w), .instr_width_p(instr_w),
    .fu_op_width_p(op_w), .stages_p(stages)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i), .csr_v_i(csr_v_i),
    .dcache_w_v_i(dcache_w_v_i), .imm_sel_i(imm_sel_i), .fu_op_i(fu_op_i), .pc_i(pc_i),
    .instr_i(instr_i), .rs1_i(rs1_i), .imm_i(imm_i), .commit_v_i(commit_v_i),
    .itlb_miss_i(itlb_miss_i), .dtlb_miss_i(dtlb_miss_i), .v_o(v_o), .csr_cmd_v_o(csr_cmd_v_o),
    .csr_op_o(csr_op_o), .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
    .commit_pc_o(commit_pc_o), .commit_vaddr_o(commit_vaddr_o), .commit_instr_o(commit_instr_o),
    .ptw(ptw), .ptw_busy_o(ptw_busy_o), .miss_overrun_o(miss_overrun_o)
  );

  typedef struct {
    logic               v, csr_v, store, imm_sel, flush, commit;
    logic [op_w-1:0]    op;
    logic [vaddr_w-1:0] pc;
    logic [instr_w-1:0] instr;
    logic [dword_w-1:0] rs1, imm;
    logic               exp_v, exp_cmd;
    logic [dword_w-1:0] exp_data;
    logic [vaddr_w-1:0] exp_vaddr;
  } vec_t;

  vec_t tbl[$];
  int   sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, csr_v, store, imm_sel, flush, commit,
                              input logic [op_w-1:0] op, input logic [vaddr_w-1:0] pc,
                              input logic [instr_w-1:0] instr, input logic [dword_w-1:0] rs1, imm,
                              input logic exp_v, exp_cmd, input logic [dword_w-1:0] exp_data,
                              input logic [vaddr_w-1:0] exp_vaddr);
    vec_t e;
    e.v = v; e.csr_v = csr_v; e.store = store; e.imm_sel = imm_sel; e.flush = flush;
    e.commit = commit; e.op = op; e.pc = pc; e.instr = instr; e.rs1 = rs1; e.imm = imm;
    e.exp_v = exp_v; e.exp_cmd = exp_cmd; e.exp_data = exp_data; e.exp_vaddr = exp_vaddr;
    return e;
  endfunction

  task automatic drive(input vec_t e);
    v_i = e.v; csr_v_i = e.csr_v; dcache_w_v_i = e.store; imm_sel_i = e.imm_sel;
    flush_i = e.flush; fu_op_i = e.op; pc_i = e.pc; instr_i = e.instr; rs1_i = e.rs1; imm_i = e.imm;
  endtask

  task automatic check_idle_ptw(input string tag);
    check({tag, "_miss_v"}, ptw.miss_v, 1'b0);
    check({tag, "_busy"}, ptw_busy_o, 1'b0);
    check({tag, "_instr"}, ptw.miss_instr, 1'b0);
    check({tag, "_store"}, ptw.miss_store, 1'b0);
    check({tag, "_vaddr"}, ptw.miss_vaddr, '0);
  endtask

  initial begin
    vec_t idle;
    int   idx;
    idle = mk(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, '0, 0, 0, '0, '0);
    drive(idle);
    reset_i = 1'b1; commit_v_i = 1'b1; itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0;
    ptw.miss_ready = 1'b0; ptw.fill_v = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_v_o", v_o, 1'b0);
    check("reset_csr_cmd", csr_cmd_v_o, 1'b0);
    check("reset_overrun", miss_overrun_o, 1'b0);
    check_idle_ptw("reset");
    reset_i = 1'b0; commit_v_i = 1'b0;

    //             v  cv st is fl cm  op     pc                instr           rs1                      imm        ev ec exp_data                  exp_vaddr
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5'h00, 39'h1000,       32'h0000_0013, 64'h10,                  64'h4,      1, 0, 64'h10,                  39'h14));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 5'h01, 39'h1004,       32'h0040_0093, 64'h100,                 64'h4,      1, 0, 64'h4,                   39'h104));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 5'h02, 39'h1008,       32'h00a1_2023, 64'h2000,                64'h8,      1, 0, 64'h2000,                39'h2008));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5'h03, 39'h100c,       32'h3010_2073, 64'h55,                  64'h1,      1, 0, 64'h55,                  39'h56));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5'h01, 39'h1010,       32'h3000_1073, 64'hAAAA,                64'h5,      1, 1, 64'h5,                   39'hAAAF));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 5'h01, 39'h1014,       32'h3000_1073, 64'hAAAA,                64'h5,      1, 0, 64'h5,                   39'hAAAF));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 5'h02, 39'h1018,       32'h3420_2073, 64'hDEAD_BEEF_0000_1234, 64'h10,     1, 1, 64'hDEAD_BEEF_0000_1234, 39'h6F_0000_1244));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 5'h02, 39'h1020,       32'h3420_2073, 64'h1,                   64'h1,      0, 0, 64'h1,                   39'h2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5'h00, 39'h1024,       32'h0000_0013, 64'h0,                   64'h0,      0, 0, 64'h0,                   39'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 5'h04, 39'h2000,       32'h0010_0113, 64'h40,                  64'h3,      1, 0, 64'h40,                  39'h43));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 5'h00, 39'h2004,       32'h0201_3023, 64'h7F_FFFF_FFF0,        64'h20,     1, 0, 64'h7F_FFFF_FFF0,        39'h10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'h00, 39'h2008,       32'h0000_0013, 64'h0,                   64'h0,      0, 0, 64'h0,                   39'h0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 5'h02, 39'h200c,       32'h3000_2073, 64'h9,                   64'h9,      0, 0, 64'h9,                   39'h12));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5'h1f, 39'h7F_FFFF_FFFC, 32'hFFF0_0073, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,   1, 1, 64'h1,                   39'h0));

    for (int i = 0; i < stages; i++) sb.push_back(-1);
    for (int i = 0; i < tbl.size() + stages; i++) begin
      @(negedge clk);
      idx = sb.pop_front();
      commit_v_i = (idx >= 0) ? tbl[idx].commit : 1'b0;
      if (i < tbl.size()) begin
        drive(tbl[i]);
        sb.push_back(i);
      end else begin
        drive(idle);
        sb.push_back(-1);
      end
      #1;
      if (idx < 0) begin
        check("idle_v_o", v_o, 1'b0);
        check("idle_csr_cmd", csr_cmd_v_o, 1'b0);
      end else begin
        check($sformatf("v_o[%0d]", idx), v_o, tbl[idx].exp_v);
        check($sformatf("csr_cmd[%0d]", idx), csr_cmd_v_o, tbl[idx].exp_cmd);
        if (tbl[idx].exp_v) begin
          check($sformatf("pc[%0d]", idx), commit_pc_o, tbl[idx].pc);
          check($sformatf("instr[%0d]", idx), commit_instr_o, tbl[idx].instr);
          check($sformatf("csr_addr[%0d]", idx), csr_addr_o, tbl[idx].instr[31:20]);
          check($sformatf("csr_op[%0d]", idx), csr_op_o, tbl[idx].op);
          check($sformatf("csr_data[%0d]", idx), csr_data_o, tbl[idx].exp_data);
          check($sformatf("vaddr[%0d]", idx), commit_vaddr_o, tbl[idx].exp_vaddr);
        end
      end
    end

    // dtlb store miss with 39-bit wrap, ready held low, stray fill in REQ
    @(negedge clk);
    pc_i = 39'h3000; rs1_i = 64'h7F_FFFF_FFF0; imm_i = 64'h20; dcache_w_v_i = 1'b1; v_i = 1'b1;
    @(negedge clk); v_i = 1'b0;
    @(negedge clk); commit_v_i = 1'b1; dtlb_miss_i = 1'b1; #1;
    check("a_commit_vaddr", commit_vaddr_o, 39'h10);
    check("a_overrun_idle", miss_overrun_o, 1'b0);
    check("a_busy_pre", ptw_busy_o, 1'b0);
    @(negedge clk);
    commit_v_i = 1'b0; dtlb_miss_i = 1'b0; pc_i = 39'h9999; rs1_i = 64'h0; dcache_w_v_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ptw.fill_v = (k == 1);
      #1;
      check($sformatf("a_req_v[%0d]", k), ptw.miss_v, 1'b1);
      check($sformatf("a_req_store[%0d]", k), ptw.miss_store, 1'b1);
      check($sformatf("a_req_instr[%0d]", k), ptw.miss_instr, 1'b0);
      check($sformatf("a_req_vaddr[%0d]", k), ptw.miss_vaddr, 39'h10);
      @(negedge clk);
    end
    ptw.fill_v = 1'b0; ptw.miss_ready = 1'b1; #1;
    check("a_still_req", ptw.miss_v, 1'b1);
    @(negedge clk); ptw.miss_ready = 1'b0; #1;
    check("a_wait_miss_v", ptw.miss_v, 1'b0);
    check("a_wait_busy", ptw_busy_o, 1'b1);
    ptw.fill_v = 1'b1;
    @(negedge clk); ptw.fill_v = 1'b0; #1;
    check_idle_ptw("a_after_fill");

    // itlb+dtlb priority, overrun in WAIT, miss colliding with fill
    pc_i = 39'h4000; rs1_i = 64'h100; imm_i = 64'h0; dcache_w_v_i = 1'b1; v_i = 1'b1;
    @(negedge clk); v_i = 1'b0;
    @(negedge clk); commit_v_i = 1'b1; itlb_miss_i = 1'b1; dtlb_miss_i = 1'b1;
    @(negedge clk);
    commit_v_i = 1'b0; itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0;
    pc_i = 39'h5000; rs1_i = 64'h200; #1;
    check("b_req_v", ptw.miss_v, 1'b1);
    check("b_req_instr", ptw.miss_instr, 1'b1);
    check("b_req_store", ptw.miss_store, 1'b0);
    check("b_req_vaddr", ptw.miss_vaddr, 39'h4000);
    ptw.miss_ready = 1'b1;
    @(negedge clk); ptw.miss_ready = 1'b0; commit_v_i = 1'b1; dtlb_miss_i = 1'b1; #1;
    check("b_wait_busy", ptw_busy_o, 1'b1);
    check("b_overrun_pulse", miss_overrun_o, 1'b1);
    @(negedge clk); commit_v_i = 1'b0; dtlb_miss_i = 1'b0; #1;
    check("b_overrun_clear", miss_overrun_o, 1'b0);
    check("b_kept_busy", ptw_busy_o, 1'b1);
    check("b_kept_instr", ptw.miss_instr, 1'b1);
    check("b_kept_vaddr", ptw.miss_vaddr, 39'h4000);
    ptw.fill_v = 1'b1; commit_v_i = 1'b1; dtlb_miss_i = 1'b1; #1;
    check("b_fill_collide_overrun", miss_overrun_o, 1'b1);
    @(negedge clk); ptw.fill_v = 1'b0; commit_v_i = 1'b0; dtlb_miss_i = 1'b0; #1;
    check_idle_ptw("b_collide_dropped");
    commit_v_i = 1'b1; dtlb_miss_i = 1'b1; #1;
    check("b_new_miss_overrun", miss_overrun_o, 1'b0);
    @(negedge clk); commit_v_i = 1'b0; dtlb_miss_i = 1'b0; #1;
    check("b_new_req_v", ptw.miss_v, 1'b1);
    check("b_new_req_store", ptw.miss_store, 1'b1);
    check("b_new_req_vaddr", ptw.miss_vaddr, 39'h200);
    ptw.miss_ready = 1'b1;
    @(negedge clk); ptw.miss_ready = 1'b0; #1;
    check("b_new_wait_busy", ptw_busy_o, 1'b1);

    // reset mid-walk, then a late fill must not disturb IDLE
    reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0; #1;
    check_idle_ptw("c_after_reset");
    ptw.fill_v = 1'b1;
    @(negedge clk); ptw.fill_v = 1'b0; #1;
    check_idle_ptw("c_late_fill");
    check("c_v_o", v_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
